// File: rtl/cic_pkg.sv
// ---------------------------------------------------------------------------
// cic_pkg
//
// Shared definitions for the CIC filter family (decimator now, interpolator
// later).
//
// Contents:
//   clog2             ceiling log2 usable in constant expressions
//   cic_acc_w         internal datapath width with full Hogenauer bit growth
//   cic_params_ok     legal-range check for order, rate and differential delay
//   cic_scale_e       how the last comb output is mapped onto the output port
//   cic_scale_mode    picks the scaling mode from the two widths
// ---------------------------------------------------------------------------
package cic_pkg;

    localparam int CIC_MIN_N = 1;
    localparam int CIC_MAX_N = 6;
    localparam int CIC_MIN_R = 2;
    localparam int CIC_MIN_M = 1;
    localparam int CIC_MAX_M = 2;

    // Output mapping: keep the MSBs when the accumulator is wider than the
    // port, otherwise sign-extend the full accumulator.
    typedef enum logic {
        SCALE_TRUNC = 1'b0,
        SCALE_SEXT  = 1'b1
    } cic_scale_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Worst-case growth is (R*M)^N, i.e. N*clog2(R*M) extra bits.
    function automatic int cic_acc_w(input int in_w, input int n, input int r, input int m);
        return in_w + n * clog2(r * m);
    endfunction

    function automatic bit cic_params_ok(input int n, input int r, input int m);
        return (n >= CIC_MIN_N) && (n <= CIC_MAX_N) &&
               (r >= CIC_MIN_R) &&
               (m >= CIC_MIN_M) && (m <= CIC_MAX_M);
    endfunction

    function automatic cic_scale_e cic_scale_mode(input int acc_w, input int out_w);
        return (acc_w > out_w) ? SCALE_TRUNC : SCALE_SEXT;
    endfunction

endpackage

// File: rtl/cic_decimator_comb.sv
// ---------------------------------------------------------------------------
// cic_comb_stage
//
// One differential-delay comb section running at the decimated rate.
// Every strobe computes out = in - in[n-M] and pushes the input into an
// M-deep delay line. The strobe is registered alongside the data so a chain
// of these stages forms a self-timed pipeline with one register per stage.
//
// Parameters:
//   W   datapath width (modular arithmetic, no saturation)
//   M   differential delay in decimated samples (1 or 2)
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   in_stb    in_data is a new decimated sample this cycle
//   in_data   comb input sample
//   out_stb   out_data was updated on the previous edge (token passed on)
//   out_data  comb output sample, held between strobes
// ---------------------------------------------------------------------------
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int W = 14,
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_stb,
    input  logic [W-1:0] in_data,
    output logic         out_stb,
    output logic [W-1:0] out_data
);

    logic [W-1:0] dly_q [M];
    logic [W-1:0] dly_d [M];
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         stb_q;
    logic         stb_d;

    // The delay line only shifts on a strobe, so its depth is counted in
    // decimated samples regardless of how far apart the strobes arrive.
    always_comb begin
        dly_d  = dly_q;
        data_d = data_q;
        stb_d  = in_stb;
        if (in_stb) begin
            data_d   = in_data - dly_q[M-1];
            dly_d[0] = in_data;
            for (int i = 1; i < M; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                dly_q[i] <= '0;
            end
            data_q <= '0;
            stb_q  <= 1'b0;
        end else begin
            dly_q  <= dly_d;
            data_q <= data_d;
            stb_q  <= stb_d;
        end
    end

    assign out_stb  = stb_q;
    assign out_data = data_q;

endmodule

// File: rtl/cic_decimator.sv
// ---------------------------------------------------------------------------
// cic_decimator
//
// N-stage CIC decimator with full Hogenauer bit growth. Integrators run on
// every accepted input sample; combs run once per R accepts. Input gaps
// (in_valid low) simply freeze the integrators and phase counter, so the
// output sequence depends only on the accepted samples.
//
// Parameters:
//   IN_W   input sample width (signed)
//   OUT_W  output sample width (signed)
//   N      filter order, 1..6
//   R      decimation factor, >= 2
//   M      differential delay, 1 or 2
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   in_data is accepted on this edge
//   in_data    input sample
//   out_valid  one-cycle strobe, out_data is new
//   out_data   decimated output, held until the next strobe
//
// Latency: out_valid rises N+2 edges after the window-completing accept.
// ---------------------------------------------------------------------------
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int N     = 3,
    parameter int R     = 4,
    parameter int M     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);

    localparam int         ACC_W      = cic_acc_w(IN_W, N, R, M);
    localparam int         PH_W       = (clog2(R) > 0) ? clog2(R) : 1;
    localparam cic_scale_e SCALE_MODE = cic_scale_mode(ACC_W, OUT_W);
    localparam int         SHIFT      = (SCALE_MODE == SCALE_TRUNC) ? (ACC_W - OUT_W) : 0;

    generate
        if (!cic_params_ok(N, R, M)) begin : g_param_check
            $fatal(1, "cic_decimator: illegal parameters (need 1<=N<=6, R>=2, M in {1,2})");
        end
    endgenerate

    logic [ACC_W-1:0] in_ext;
    logic [PH_W-1:0]  phase_q;
    logic [PH_W-1:0]  phase_d;
    logic             wca;
    logic             dec_stb_q;
    logic             dec_stb_d;
    logic [ACC_W-1:0] comb_in_q;
    logic [ACC_W-1:0] comb_in_d;
    logic             comb_in_stb_q;
    logic             comb_in_stb_d;
    logic [ACC_W-1:0] comb_last;
    logic             comb_last_stb;
    logic [ACC_W-1:0] scaled_acc;
    logic [OUT_W-1:0] scaled;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [OUT_W-1:0] out_data_q;
    logic [OUT_W-1:0] out_data_d;

    assign in_ext = ACC_W'($signed(in_data));

    // Integrator chain. Each stage adds the previous stage's registered value,
    // so the chain is pipelined and the whole chain only moves on an accept.
    // Wraparound is intentional: the combs cancel it exactly.
    generate
        for (genvar k = 0; k < N; k++) begin : g_integ
            logic [ACC_W-1:0] acc_q;
            logic [ACC_W-1:0] acc_d;
            logic [ACC_W-1:0] addend;

            if (k == 0) begin : g_src
                assign addend = in_ext;
            end else begin : g_src
                assign addend = g_integ[k-1].acc_q;
            end

            always_comb begin
                acc_d = acc_q;
                if (in_valid) begin
                    acc_d = acc_q + addend;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    endgenerate

    // Phase counter and decimation strobe. The accept that sees phase R-1
    // completes a window; the strobe is registered so the comb input samples
    // the last integrator one edge later, after it has absorbed that accept.
    always_comb begin
        wca       = in_valid && (phase_q == PH_W'(R - 1));
        phase_d   = phase_q;
        dec_stb_d = wca;
        if (in_valid) begin
            phase_d = wca ? '0 : phase_q + 1'b1;
        end
    end

    // Comb input register: holds the decimated integrator sample and
    // launches the token that walks down the comb pipeline.
    always_comb begin
        comb_in_d     = comb_in_q;
        comb_in_stb_d = dec_stb_q;
        if (dec_stb_q) begin
            comb_in_d = g_integ[N-1].acc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= '0;
            dec_stb_q     <= 1'b0;
            comb_in_q     <= '0;
            comb_in_stb_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            dec_stb_q     <= dec_stb_d;
            comb_in_q     <= comb_in_d;
            comb_in_stb_q <= comb_in_stb_d;
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_comb
            logic [ACC_W-1:0] stage_in;
            logic             stage_in_stb;
            logic [ACC_W-1:0] stage_out;
            logic             stage_out_stb;

            if (k == 0) begin : g_src
                assign stage_in     = comb_in_q;
                assign stage_in_stb = comb_in_stb_q;
            end else begin : g_src
                assign stage_in     = g_comb[k-1].stage_out;
                assign stage_in_stb = g_comb[k-1].stage_out_stb;
            end

            cic_comb_stage #(
                .W (ACC_W),
                .M (M)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .in_stb   (stage_in_stb),
                .in_data  (stage_in),
                .out_stb  (stage_out_stb),
                .out_data (stage_out)
            );
        end
    endgenerate

    assign comb_last     = g_comb[N-1].stage_out;
    assign comb_last_stb = g_comb[N-1].stage_out_stb;

    // An arithmetic shift followed by a narrowing cast keeps exactly the top
    // OUT_W bits (plain truncation, no rounding); with SHIFT == 0 the signed
    // cast sign-extends instead.
    assign scaled_acc = $signed(comb_last) >>> SHIFT;
    assign scaled     = OUT_W'($signed(scaled_acc));

    always_comb begin
        out_valid_d = comb_last_stb;
        out_data_d  = out_data_q;
        if (comb_last_stb) begin
            out_data_d = scaled;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_cic_decimator
//
// Three decimator instances share one stimulus stream:
//   u_dflt  defaults (N=3, R=4, M=1, OUT_W=16, ACC_W=14)
//   u_w12   OUT_W=12 (ACC_W=14, output truncated by 2 bits)
//   u_n2    N=2, R=8, M=2 (ACC_W=16)
// A behavioural model of every instance pushes the expected output and its
// arrival cycle into a per-instance queue on each accept; a monitor pops and
// compares whenever an instance raises out_valid. Scenario tasks add their
// own checks on timing, spacing and steady-state values.
// ---------------------------------------------------------------------------
module tb_cic_decimator;

    localparam int NI = 3;

    typedef logic signed [63:0] val_t;
    typedef struct {
        longint data;
        int     cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        dflt_valid;
    logic [15:0] dflt_data;
    logic        w12_valid;
    logic [11:0] w12_data;
    logic        n2_valid;
    logic [15:0] n2_data;

    int     cyc    = 0;
    int     total  = 0;
    int     passed = 0;

    exp_t   sb [NI][$];
    longint integ [NI][6];
    longint dly [NI][6][2];
    int     phase [NI];

    int     run_inst;
    val_t   run_vals[$];
    int     run_cycs[$];
    int     first_acc;
    val_t   fresh_seq[$];

    cic_decimator u_dflt (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (dflt_valid),
        .out_data  (dflt_data)
    );

    cic_decimator #(.OUT_W(12)) u_w12 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (w12_valid),
        .out_data  (w12_data)
    );

    cic_decimator #(.N(2), .R(8), .M(2)) u_n2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (n2_valid),
        .out_data  (n2_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_n(input int i);  return (i == 2) ? 2 : 3;   endfunction
    function automatic int cfg_r(input int i);  return (i == 2) ? 8 : 4;   endfunction
    function automatic int cfg_m(input int i);  return (i == 2) ? 2 : 1;   endfunction
    function automatic int cfg_aw(input int i); return (i == 2) ? 16 : 14; endfunction
    function automatic int cfg_ow(input int i); return (i == 1) ? 12 : 16; endfunction

    function automatic logic get_valid(input int i);
        case (i)
            0:       return dflt_valid;
            1:       return w12_valid;
            default: return n2_valid;
        endcase
    endfunction

    function automatic val_t get_data(input int i);
        case (i)
            0:       return val_t'($signed(dflt_data));
            1:       return val_t'($signed(w12_data));
            default: return val_t'($signed(n2_data));
        endcase
    endfunction

    // Two's complement wrap of v to w bits, returned sign-extended.
    function automatic longint wrap(input longint v, input int w);
        longint modulus;
        longint r;
        modulus = longint'(1) << w;
        r = v & (modulus - 1);
        if (r[w-1]) r = r - modulus;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 6; k++) begin
                integ[i][k]  = 0;
                dly[i][k][0] = 0;
                dly[i][k][1] = 0;
            end
            phase[i] = 0;
            sb[i].delete();
        end
    endtask

    // Integrators follow I_k += old I_(k-1); on a window-completing accept the
    // freshly updated last integrator feeds the comb cascade.
    task automatic model_accept(input int i, input longint x);
        int     n, r, m, aw, ow;
        longint v, c;
        exp_t   e;
        n  = cfg_n(i);
        r  = cfg_r(i);
        m  = cfg_m(i);
        aw = cfg_aw(i);
        ow = cfg_ow(i);
        for (int k = n - 1; k >= 1; k--) begin
            integ[i][k] = wrap(integ[i][k] + integ[i][k-1], aw);
        end
        integ[i][0] = wrap(integ[i][0] + x, aw);
        if (phase[i] == r - 1) begin
            phase[i] = 0;
            v = integ[i][n-1];
            for (int k = 0; k < n; k++) begin
                c = wrap(v - dly[i][k][m-1], aw);
                dly[i][k][1] = dly[i][k][0];
                dly[i][k][0] = v;
                v = c;
            end
            e.data = (aw > ow) ? (v >>> (aw - ow)) : v;
            e.cyc  = cyc + 1 + n + 2;
            sb[i].push_back(e);
        end else begin
            phase[i] = phase[i] + 1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else if (in_valid) begin
            for (int i = 0; i < NI; i++) begin
                model_accept(i, longint'($signed(in_data)));
            end
        end
    end

    // Scoreboard monitor: every out_valid must match the next expected output
    // in both value and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (get_valid(i) === 1'b1) begin
                total++;
                if (sb[i].size() == 0) begin
                    $display("[TB] FAIL sb_unexpected_inst%0d: out_valid at cycle %0d, required no output", i, cyc);
                end else begin
                    e = sb[i].pop_front();
                    if (get_data(i) !== val_t'(e.data) || cyc != e.cyc)
                        $display("[TB] FAIL sb_inst%0d: got data %0d at cycle %0d, required data %0d at cycle %0d",
                                 i, get_data(i), cyc, e.data, e.cyc);
                    else
                        passed++;
                end
            end
        end
    end

    task automatic sample_run();
        if (get_valid(run_inst) === 1'b1) begin
            run_vals.push_back(get_data(run_inst));
            run_cycs.push_back(cyc);
        end
    endtask

    task automatic clear_run(input int inst);
        run_inst  = inst;
        run_vals.delete();
        run_cycs.delete();
        first_acc = -1;
    endtask

    task automatic stream(input int cycles, input logic [7:0] d, input bit gapped);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            sample_run();
            in_valid = gapped ? ~c[0] : 1'b1;
            in_data  = d;
            if (in_valid && first_acc < 0) first_acc = cyc + 1;
        end
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            sample_run();
            in_valid = 1'b0;
            in_data  = 8'd0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (get_valid(i) !== 1'b0)
                $display("[TB] FAIL reset_valid_inst%0d: got %b, required 0", i, get_valid(i));
            else passed++;
            total++;
            if (get_data(i) !== val_t'(0))
                $display("[TB] FAIL reset_data_inst%0d: got %0d, required 0", i, get_data(i));
            else passed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_ones();
        int   bad;
        int   got_cyc;
        val_t got;
        apply_reset();
        clear_run(0);
        stream(60, 8'd1, 1'b0);
        idle(12);
        total++;
        if (run_vals.size() != 15)
            $display("[TB] FAIL ones_count: got %0d outputs, required 15", run_vals.size());
        else passed++;
        got_cyc = (run_cycs.size() > 0) ? run_cycs[0] : -1;
        total++;
        if (got_cyc != first_acc + 8)
            $display("[TB] FAIL ones_first_latency: got cycle %0d, required %0d", got_cyc, first_acc + 8);
        else passed++;
        bad = 0;
        for (int k = 1; k < run_cycs.size(); k++)
            if (run_cycs[k] - run_cycs[k-1] != 4) bad++;
        total++;
        if (bad != 0)
            $display("[TB] FAIL ones_spacing: got %0d gaps not equal to 4, required 0", bad);
        else passed++;
        got = (run_vals.size() > 1) ? run_vals[0] : 'x;
        total++;
        if (got !== val_t'(4))
            $display("[TB] FAIL ones_first_value: got %0d, required 4", got);
        else passed++;
        got = (run_vals.size() > 1) ? run_vals[1] : 'x;
        total++;
        if (got !== val_t'(44))
            $display("[TB] FAIL ones_second_value: got %0d, required 44", got);
        else passed++;
        got = (run_vals.size() > 3) ? run_vals[3] : 'x;
        total++;
        if (got !== val_t'(64))
            $display("[TB] FAIL ones_settled: got %0d, required 64", got);
        else passed++;
        fresh_seq = run_vals;
    endtask

    task automatic test_full_scale();
        int   bad;
        val_t got;
        apply_reset();
        clear_run(0);
        stream(10000, 8'd127, 1'b0);
        bad = 0;
        for (int k = 3; k < run_vals.size(); k++)
            if (run_vals[k] !== val_t'(8128)) bad++;
        total++;
        if (bad != 0 || run_vals.size() < 2400)
            $display("[TB] FAIL max_steady: got %0d disturbed of %0d outputs, required 0 of >=2400", bad, run_vals.size());
        else passed++;
        got = (run_vals.size() > 0) ? run_vals[run_vals.size()-1] : 'x;
        total++;
        if (got !== val_t'(8128))
            $display("[TB] FAIL max_dflt: got %0d, required 8128", got);
        else passed++;
        total++;
        if (w12_data !== 12'd2032)
            $display("[TB] FAIL max_w12: got %0d, required 2032", $signed(w12_data));
        else passed++;
        total++;
        if (n2_data !== 16'd32512)
            $display("[TB] FAIL max_n2: got %0d, required 32512", $signed(n2_data));
        else passed++;
        clear_run(0);
        stream(200, 8'h80, 1'b0);
        idle(12);
        total++;
        if (dflt_data !== 16'hE000)
            $display("[TB] FAIL min_dflt: got %0d, required -8192", $signed(dflt_data));
        else passed++;
        total++;
        if (w12_data !== 12'h800)
            $display("[TB] FAIL min_w12: got %0d, required -2048", $signed(w12_data));
        else passed++;
        total++;
        if (n2_data !== 16'h8000)
            $display("[TB] FAIL min_n2: got %0d, required -32768", $signed(n2_data));
        else passed++;
    endtask

    task automatic test_gaps();
        val_t seq_a[$];
        int   bad;
        int   mism;
        val_t got;
        apply_reset();
        clear_run(0);
        stream(80, 8'd5, 1'b0);
        idle(12);
        seq_a = run_vals;
        apply_reset();
        clear_run(0);
        stream(160, 8'd5, 1'b1);
        idle(12);
        total++;
        if (run_vals.size() != 20 || seq_a.size() != 20)
            $display("[TB] FAIL gaps_count: got %0d gapped / %0d gapless outputs, required 20 / 20", run_vals.size(), seq_a.size());
        else passed++;
        mism = 0;
        for (int k = 0; k < run_vals.size() && k < seq_a.size(); k++)
            if (run_vals[k] !== seq_a[k]) mism++;
        total++;
        if (mism != 0)
            $display("[TB] FAIL gaps_sequence: got %0d differing outputs, required 0", mism);
        else passed++;
        bad = 0;
        for (int k = 1; k < run_cycs.size(); k++)
            if (run_cycs[k] - run_cycs[k-1] != 8) bad++;
        total++;
        if (bad != 0)
            $display("[TB] FAIL gaps_spacing: got %0d gaps not equal to 8, required 0", bad);
        else passed++;
        got = (run_vals.size() > 0) ? run_vals[run_vals.size()-1] : 'x;
        total++;
        if (got !== val_t'(320))
            $display("[TB] FAIL gaps_steady: got %0d, required 320", got);
        else passed++;
    endtask

    task automatic test_order2();
        int   bad;
        int   got_cyc;
        val_t got;
        apply_reset();
        clear_run(2);
        stream(200, 8'd3, 1'b0);
        idle(16);
        total++;
        if (run_vals.size() != 25)
            $display("[TB] FAIL n2_count: got %0d outputs, required 25", run_vals.size());
        else passed++;
        got_cyc = (run_cycs.size() > 0) ? run_cycs[0] : -1;
        total++;
        if (got_cyc != first_acc + 11)
            $display("[TB] FAIL n2_first_latency: got cycle %0d, required %0d", got_cyc, first_acc + 11);
        else passed++;
        bad = 0;
        for (int k = 1; k < run_cycs.size(); k++)
            if (run_cycs[k] - run_cycs[k-1] != 8) bad++;
        total++;
        if (bad != 0)
            $display("[TB] FAIL n2_spacing: got %0d gaps not equal to 8, required 0", bad);
        else passed++;
        got = (run_vals.size() > 0) ? run_vals[run_vals.size()-1] : 'x;
        total++;
        if (got !== val_t'(768))
            $display("[TB] FAIL n2_steady: got %0d, required 768", got);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int mism;
        int got_cyc;
        apply_reset();
        clear_run(0);
        stream(4, 8'd1, 1'b0);
        @(negedge clk);
        sample_run();
        in_valid = 1'b0;
        @(negedge clk);
        sample_run();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            sample_run();
        end
        rst = 1'b0;
        idle(20);
        total++;
        if (run_vals.size() != 0)
            $display("[TB] FAIL midreset_quiet: got %0d outputs, required 0", run_vals.size());
        else passed++;
        clear_run(0);
        stream(60, 8'd1, 1'b0);
        idle(12);
        total++;
        if (run_vals.size() != fresh_seq.size())
            $display("[TB] FAIL midreset_count: got %0d outputs, required %0d", run_vals.size(), fresh_seq.size());
        else passed++;
        mism = 0;
        for (int k = 0; k < run_vals.size() && k < fresh_seq.size(); k++)
            if (run_vals[k] !== fresh_seq[k]) mism++;
        total++;
        if (mism != 0)
            $display("[TB] FAIL midreset_sequence: got %0d differing outputs, required 0", mism);
        else passed++;
        got_cyc = (run_cycs.size() > 0) ? run_cycs[0] : -1;
        total++;
        if (got_cyc != first_acc + 8)
            $display("[TB] FAIL midreset_latency: got cycle %0d, required %0d", got_cyc, first_acc + 8);
        else passed++;
    endtask

    task automatic test_drain();
        idle(30);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (sb[i].size() != 0)
                $display("[TB] FAIL drain_inst%0d: got %0d outputs still pending, required 0", i, sb[i].size());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_full_scale();
        test_gaps();
        test_order2();
        test_reset_mid();
        test_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL timeout: simulation still running at time %0t, required completion", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
